// File: rtl/demux_14_pkg.sv
// Shared constants and types for the demux_14 1-to-4 registered demultiplexer.
package demux_14_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_D0 = 2'd0;
   localparam sel_t SEL_D1 = 2'd1;
   localparam sel_t SEL_D2 = 2'd2;
   localparam sel_t SEL_D3 = 2'd3;

endpackage : demux_14_pkg

// File: rtl/demux_14_sat_cnt.sv
// Saturating transfer counter with synchronous clear; clear wins over increment.
module demux_14_sat_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear first, then increment unless already at full scale
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : demux_14_sat_cnt

// File: rtl/demux_14.sv
// Registered 1-to-4 demultiplexer with one-hot valid and optional per-channel
// saturating transfer counters, enabled by defining DEMUX_14_CNT_EN.
module demux_14
   import demux_14_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic [NCH-1:0]   d_valid,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   sel_t             sel;
   logic [WIDTH-1:0] d_q [NCH];
   logic [WIDTH-1:0] d_d [NCH];
   logic [NCH-1:0]   valid_q;
   logic [NCH-1:0]   valid_d;
   logic [CNT_W-1:0] cnt_w [NCH];

   assign sel = {s1, s0};

   // Steer data to the selected lane (others zero, independent of valid) and build one-hot valid
   always_comb begin
      d_d     = '{default: '0};
      valid_d = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (sel == SEL_W'(k)) begin
            d_d[k] = in;
         end
      end
      if (in_valid) begin
         valid_d = NCH'(1) << sel;
      end
   end

   // Output registers; reset clears data and valid asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q     <= '{default: '0};
         valid_q <= '0;
      end else begin
         d_q     <= d_d;
         valid_q <= valid_d;
      end
   end

`ifdef DEMUX_14_CNT_EN
   // One saturating counter per channel, bumped on accepted transfers to that channel
   for (genvar k = 0; k < NCH; k++) begin : g_cnt
      demux_14_sat_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (in_valid && (sel == SEL_W'(k))),
         .clr   (cnt_clr),
         .count (cnt_w[k])
      );
   end
`else
   // Counters absent: outputs held at zero and the clear input is intentionally unused
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   for (genvar k = 0; k < NCH; k++) begin : g_cnt_off
      assign cnt_w[k] = '0;
   end
`endif

   assign d0      = d_q[0];
   assign d1      = d_q[1];
   assign d2      = d_q[2];
   assign d3      = d_q[3];
   assign d_valid = valid_q;
   assign cnt0    = cnt_w[0];
   assign cnt1    = cnt_w[1];
   assign cnt2    = cnt_w[2];
   assign cnt3    = cnt_w[3];

endmodule : demux_14

// File: tb/tb_demux_14.sv
// Self-checking bench for demux_14 (WIDTH=1, CNT_W=2). Counter expectations
// follow DEMUX_14_CNT_EN: modelled when defined, zero otherwise.
module tb_demux_14;
   import demux_14_pkg::*;

   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [3:0] d;     // {d0,d1,d2,d3}
      logic [3:0] dv;
      logic [7:0] cnt;   // {cnt3,cnt2,cnt1,cnt0}
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [0:0]       tb_in = 1'b0;
   logic             tb_valid = 1'b0;
   logic             s1 = 1'b0;
   logic             s0 = 1'b0;
   logic             cnt_clr = 1'b0;
   logic [0:0]       d0, d1, d2, d3;
   logic [3:0]       d_valid;
   logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

   exp_t             sb[$];
   logic [CNT_W-1:0] mcnt [4];
   int               n_cmp = 0;
   int               n_err = 0;

   demux_14 #(
      .WIDTH (1),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (tb_in),
      .in_valid (tb_valid),
      .s1       (s1),
      .s0       (s0),
      .d0       (d0),
      .d1       (d1),
      .d2       (d2),
      .d3       (d3),
      .d_valid  (d_valid),
      .cnt_clr  (cnt_clr),
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .cnt3     (cnt3)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] pack_cnt();
      return {2'(mcnt[3]), 2'(mcnt[2]), 2'(mcnt[1]), 2'(mcnt[0])};
   endfunction

   // Pop the oldest expectation and compare it to current DUT outputs
   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      assert ({d0, d1, d2, d3} === e.d) else begin
         n_err++;
         $error("FAIL %s.data: observed %b expected %b", tag, {d0, d1, d2, d3}, e.d);
      end
      n_cmp++;
      assert (d_valid === e.dv) else begin
         n_err++;
         $error("FAIL %s.valid: observed %b expected %b", tag, d_valid, e.dv);
      end
      n_cmp++;
      assert ({cnt3, cnt2, cnt1, cnt0} === e.cnt) else begin
         n_err++;
         $error("FAIL %s.cnt: observed %h expected %h", tag, {cnt3, cnt2, cnt1, cnt0}, e.cnt);
      end
   endtask

   // Expect everything at zero (reset state) right now
   task automatic check_zero(input string tag);
      exp_t e;
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
      e = '0;
      sb.push_back(e);
      check_out(tag);
   endtask

   // Drive one cycle of stimulus, predict the registered result, compare after the edge
   task automatic step(input logic din, input logic v, input logic [1:0] s,
                       input logic clr, input string tag);
      exp_t       e;
      logic [3:0] one;
      one      = 4'b0001;
      tb_in    = din;
      tb_valid = v;
      {s1, s0} = s;
      cnt_clr  = clr;
      e.d = '0;
      for (int k = 0; k < 4; k++) begin
         if (int'(s) == k) e.d[3-k] = din;
      end
      e.dv = v ? (one << s) : 4'b0000;
`ifdef DEMUX_14_CNT_EN
      if (clr) begin
         for (int k = 0; k < 4; k++) mcnt[k] = '0;
      end else if (v && (mcnt[s] != 2'd3)) begin
         mcnt[s] = mcnt[s] + 2'd1;
      end
`endif
      e.cnt = pack_cnt();
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) mcnt[k] = '0;

      // Asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1 check_zero("reset_async");
      @(posedge clk);
      #1 check_zero("reset_held");
      rst = 1'b0;

      // Walking select with in=1
      step(1'b1, 1'b1, SEL_D0, 1'b0, "walk_sel0");
      step(1'b1, 1'b1, SEL_D1, 1'b0, "walk_sel1");
      step(1'b1, 1'b1, SEL_D2, 1'b0, "walk_sel2");
      step(1'b1, 1'b1, SEL_D3, 1'b0, "walk_sel3");

      // Zero data still raises valid
      for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 2'(s), 1'b0, "zero_data");

      // Invalid transfer still routes data but no valid or count
      step(1'b1, 1'b0, SEL_D2, 1'b0, "invalid_sel2");

      // Clear, then saturation on channel 1 and clear racing an increment
      step(1'b0, 1'b0, SEL_D0, 1'b1, "clear_all");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, SEL_D1, 1'b0, "sat_ch1");
      step(1'b1, 1'b1, SEL_D1, 1'b1, "clr_wins");
      step(1'b1, 1'b1, SEL_D1, 1'b0, "after_clr");

      // Random traffic on all channels
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), "random");
      end

      // Reset pulse between edges while d3 is high
      step(1'b1, 1'b1, SEL_D3, 1'b0, "pre_rst_d3");
      #2 rst = 1'b1;
      #1 check_zero("rst_pulse");
      rst = 1'b0;

      // Transfer presented while reset spans an edge is discarded
      tb_in    = 1'b1;
      tb_valid = 1'b1;
      {s1, s0} = SEL_D2;
      rst      = 1'b1;
      @(posedge clk);
      #1 check_zero("rst_discard");
      rst = 1'b0;
      step(1'b1, 1'b1, SEL_D2, 1'b0, "post_rst_capture");
      step(1'b1, 1'b1, SEL_D0, 1'b0, "post_rst_next");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_demux_14
